// File: rtl/mem_responder.sv
// mem_responder: single-port word memory serving one load/store at a time.
//
// Ports:
//   clock      - sole clock; all state changes on the rising edge
//   reset      - asynchronous, active-low reset
//   req        - access request; taken on a rising edge where req=1 and ready=1
//   ready      - high only in IDLE; req is ignored in every other state
//   we         - 1 = store, 0 = load
//   size       - 0 = word, 1 = halfword, 2 = byte, 3 = illegal
//   addr       - byte address (big-endian lanes inside each word)
//   wdata      - store data; halfword in [15:0], byte in [7:0]
//   resp_valid - one-cycle response pulse, no backpressure
//   rdata      - load result, zero for stores and errors, zero outside the pulse
//   err        - access rejected; meaningful only with resp_valid
//   dbg_state  - current FSM state encoding, for observation only
//
// Handshake: a request transfers on a rising edge with req=1 and ready=1.
// Exactly one resp_valid pulse follows each transfer unless reset intervenes;
// the requester cannot stall the response.
//
// Response timing counted in rising edges after the accept edge:
//   error 1, load READ_LAT, word store 2, halfword/byte store 3.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [2:0]  dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR      = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rmw_q, rmw_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic              req_err;
    logic [IDX_W-1:0]  rd_idx;
    logic [31:0]       rd_word;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    // Big-endian lane selection with sign extension for sub-word loads.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  off);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? w[15:0] : w[31:16];
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        case (sz)
            2'd1:    return {{16{h[15]}}, h};
            2'd2:    return {{24{b[7]}}, b};
            default: return w;
        endcase
    endfunction

    // Replace only the addressed lanes, keep the rest of the stored word.
    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [31:0] wd,
                                          input logic [1:0]  sz,
                                          input logic [1:0]  off);
        logic [31:0] r;
        r = w;
        if (sz == 2'd1) begin
            if (off[1]) r[15:0]  = wd[15:0];
            else        r[31:16] = wd[15:0];
        end else begin
            case (off)
                2'd0:    r[31:24] = wd[7:0];
                2'd1:    r[23:16] = wd[7:0];
                2'd2:    r[15:8]  = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end
        return r;
    endfunction

    always_comb begin
        req_err = (size == 2'd3) ||
                  (size == 2'd0 && addr[1:0] != 2'd0) ||
                  (size == 2'd1 && addr[0]) ||
                  (addr[31:2] >= 30'(DEPTH_WORDS));
    end

    // In IDLE the read port looks at the live address so READ_LAT=1 can
    // answer straight from the accept edge; otherwise it uses the capture.
    always_comb begin
        rd_idx  = (state_q == IDLE) ? addr[AW-1:2] : addr_q[AW-1:2];
        rd_word = mem_q[rd_idx];
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rmw_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rmw_q   <= rmw_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. RD_WAIT lasts READ_LAT-1 cycles so that RESP is
    // visible READ_LAT edges after accept; the counter is preloaded with
    // READ_LAT-2 and RESP follows the cycle in which it reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (!we) begin
                        if (READ_LAT == 1) begin
                            state_d = RESP;
                        end else begin
                            state_d = RD_WAIT;
                            cnt_d   = 3'(READ_LAT - 2);
                        end
                    end else if (size == 2'd0) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 3'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            WR:      state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and response data path
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rmw_d   = rmw_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    addr_d  = addr[AW-1:0];
                    wdata_d = wdata;
                    err_d   = req_err;
                    rdata_d = '0;
                    if (!req_err && !we && READ_LAT == 1)
                        rdata_d = load_extract(rd_word, size, addr[1:0]);
                end
            end
            RD_WAIT: begin
                if (cnt_q == 3'd0)
                    rdata_d = load_extract(rd_word, size_q, addr_q[1:0]);
            end
            RMW_RD:  rmw_d = rd_word;
            default: ;
        endcase
    end

    // Commit happens on the edge leaving WR / RMW_WR; an asserted reset
    // has already pulled state_q to IDLE, so an aborted access never writes.
    always_comb begin
        mem_we    = (state_q == WR) || (state_q == RMW_WR);
        mem_wdata = (state_q == WR) ? wdata_q
                                    : merge(rmw_q, wdata_q, size_q, addr_q[1:0]);
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[addr_q[AW-1:2]] <= mem_wdata;
    end

    // Output logic
    always_comb begin
        ready      = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        err        = (state_q == RESP) ? err_q : 1'b0;
        rdata      = (state_q == RESP) ? rdata_q : 32'd0;
        dbg_state  = state_q;
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule
